// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity mode constants.
// Also intended for use by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// tx and busy are registered outputs.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    if (CLKS_PER_BIT < 2 || PARITY > PARITY_ODD) begin : g_param_check
        $error("uart_tx: CLKS_PER_BIT must be >= 2 and PARITY must be 0..2");
    end

    uart_tx_state_t state, state_n;
    logic [7:0]     shift_reg, shift_n;
    logic [2:0]     bit_cnt, bit_n;
    logic           par_bit, par_n;
    logic           tx_n, busy_n;
    logic           accept;
    logic           tick;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
        end else begin
            state     <= state_n;
            tx        <= tx_n;
            busy      <= busy_n;
            shift_reg <= shift_n;
            bit_cnt   <= bit_n;
            par_bit   <= par_n;
        end
    end

    // Next-state values are what tx shows for the upcoming bit, so tx stays a pure flop.
    always_comb begin
        state_n = state;
        tx_n    = tx;
        busy_n  = busy;
        shift_n = shift_reg;
        bit_n   = bit_cnt;
        par_n   = par_bit;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (send && !busy) begin
                    accept  = 1'b1;
                    shift_n = data;
                    par_n   = (PARITY == PARITY_ODD) ? ~(^data) : ^data;
                    state_n = ST_START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    bit_n   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n = ST_DATA;
                    tx_n    = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_n = {1'b0, shift_reg[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (PARITY != PARITY_NONE) begin
                            state_n = ST_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        tx_n = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_n = ST_STOP;
                    tx_n    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_n = ST_IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (no/even/odd parity) at 4 clocks per bit.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [2:0] send_v;
    logic [7:0] data_v [3];
    logic [2:0] tx_v;
    logic [2:0] busy_v;

    logic [10:0] exp_q [3][$];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference frame, bit 0 first on the line: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input int p);
        logic par;
        par = (^d) ^ (p == 2);
        if (p == 0) return {2'b01, d, 1'b0};
        return {1'b1, par, d, 1'b0};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int F = (g == 0) ? 10 : 11;

        uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(g)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .send (send_v[g]),
            .data (data_v[g]),
            .tx   (tx_v[g]),
            .busy (busy_v[g])
        );

        // Monitor: captures each frame from its first busy cycle and checks it against the queue.
        initial begin : mon
            logic        prev_busy;
            logic [10:0] got;
            logic [10:0] exp;
            logic        steady;
            logic        aborted;
            prev_busy = 1'b0;
            forever begin
                @(negedge clk);
                if (rst !== 1'b0) begin
                    prev_busy = 1'b0;
                end else if (busy_v[g] === 1'b1 && prev_busy === 1'b0) begin
                    got     = '0;
                    steady  = 1'b1;
                    aborted = 1'b0;
                    for (int b = 0; b < F && !aborted; b++) begin
                        for (int c = 0; c < CPB && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst !== 1'b0) begin
                                aborted = 1'b1;
                            end else begin
                                if (c == 0) got[b] = tx_v[g];
                                else if (tx_v[g] !== got[b]) steady = 1'b0;
                                if (busy_v[g] !== 1'b1) steady = 1'b0;
                            end
                        end
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        chk($sformatf("busy_len[%0d]", g), 32'(busy_v[g]), 32'd0);
                        chk($sformatf("idle_tx[%0d]", g), 32'(tx_v[g]), 32'd1);
                        chk($sformatf("bit_hold[%0d]", g), 32'(steady), 32'd1);
                        if (exp_q[g].size() == 0) begin
                            chk($sformatf("unexpected_frame[%0d]", g), 32'(got), 32'h7ff);
                        end else begin
                            exp = exp_q[g].pop_front();
                            chk($sformatf("frame[%0d]", g), 32'(got), 32'(exp));
                        end
                        prev_busy = busy_v[g];
                    end else begin
                        prev_busy = 1'b0;
                    end
                end else begin
                    prev_busy = busy_v[g];
                end
            end
        end
    end

    task automatic send_byte(input int p, input logic [7:0] d, input bit expect_frame);
        if (expect_frame) exp_q[p].push_back(frame_of(d, p));
        data_v[p] = d;
        send_v[p] = 1'b1;
        @(negedge clk);
        send_v[p] = 1'b0;
    endtask

    task automatic wait_busy(input int p, input logic val, input int limit);
        int n;
        n = 0;
        while (busy_v[p] !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy_v[p] !== val) chk($sformatf("wait_busy_timeout[%0d]", p), 32'(busy_v[p]), 32'(val));
    endtask

    task automatic wait_idle(input int p);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 8 && n < 200) begin
            @(negedge clk);
            n++;
            if (busy_v[p] === 1'b0) quiet++;
            else quiet = 0;
        end
        if (quiet < 8) chk($sformatf("idle_timeout[%0d]", p), 32'(busy_v[p]), 32'd0);
    endtask

    initial begin : stim
        int gap;
        rst    = 1'b1;
        send_v = '0;
        for (int p = 0; p < 3; p++) data_v[p] = 8'h00;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                chk("reset_tx", 32'(tx_v[p]), 32'd1);
                chk("reset_busy", 32'(busy_v[p]), 32'd0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_tx", 32'(tx_v[0]), 32'd1);
        chk("post_reset_busy", 32'(busy_v[0]), 32'd0);

        send_byte(0, 8'hA5, 1'b1);
        chk("latency_tx", 32'(tx_v[0]), 32'd0);
        chk("latency_busy", 32'(busy_v[0]), 32'd1);
        wait_idle(0);

        send_byte(1, 8'h07, 1'b1);
        send_byte(2, 8'h07, 1'b1);
        wait_idle(1);
        wait_idle(2);

        // A send during the frame and a data change must both leave 0x55 untouched.
        send_byte(0, 8'h55, 1'b1);
        repeat (9) @(negedge clk);
        send_byte(0, 8'h3C, 1'b0);
        data_v[0] = 8'hFF;
        repeat (8) @(negedge clk);
        data_v[0] = 8'h00;
        wait_idle(0);

        exp_q[0].push_back(frame_of(8'h01, 0));
        exp_q[0].push_back(frame_of(8'h80, 0));
        data_v[0] = 8'h01;
        send_v[0] = 1'b1;
        wait_busy(0, 1'b1, 10);
        data_v[0] = 8'h80;
        wait_busy(0, 1'b0, 60);
        gap = 0;
        while (busy_v[0] === 1'b0 && gap < 10) begin
            chk("gap_tx", 32'(tx_v[0]), 32'd1);
            gap++;
            @(negedge clk);
        end
        send_v[0] = 1'b0;
        chk("idle_gap", 32'(gap), 32'd1);
        wait_idle(0);

        // Abort during data bit 3, then a clean frame must follow.
        send_byte(0, 8'h00, 1'b0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", 32'(tx_v[0]), 32'd1);
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(0, 8'hFF, 1'b1);
        wait_idle(0);

        for (int p = 0; p < 3; p++) chk($sformatf("queue_empty[%0d]", p), 32'(exp_q[p].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timed out");
    end

endmodule
